// File: rtl/axi_rd_arb_pkg.sv
// Shared types and helpers for the single-outstanding AXI read arbiter.
package axi_rd_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  // AXI ARSIZE encoding for a full-width beat of dw bits.
  function automatic logic [2:0] axi_size_from_width(input int dw);
    logic [2:0] s;
    s = '0;
    for (int i = 0; i < 8; i++)
      if ((8 << i) == dw) s = 3'(i);
    return s;
  endfunction

endpackage

// File: rtl/axi_rd_arb_rr.sv
// Round-robin picker: first set request at or above ptr, wrapping N-1 -> 0.
module axi_rd_arb_rr #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  int   idx;
  logic found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// N-to-1 AXI read arbiter, one burst in flight, combinational R-channel routing.
// Define AXI_RD_ARB_PRIORITY_EN to give requester 0 fixed priority over the rest.
module axi_rd_arbiter
  import axi_rd_arb_pkg::*;
#(
  parameter int C_REQ_COUNT        = 4,
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 512
) (
  input  logic                                      CLK,
  input  logic                                      RST,
  input  logic [C_REQ_COUNT*C_M_AXI_ADDR_WIDTH-1:0] REQ_ARADDR,
  input  logic [C_REQ_COUNT*8-1:0]                  REQ_ARLEN,
  input  logic [C_REQ_COUNT-1:0]                    REQ_ARVALID,
  output logic [C_REQ_COUNT-1:0]                    REQ_ARREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]             REQ_RDATA,
  output logic [1:0]                                REQ_RRESP,
  output logic                                      REQ_RLAST,
  output logic [C_REQ_COUNT-1:0]                    REQ_RVALID,
  input  logic [C_REQ_COUNT-1:0]                    REQ_RREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]             M_ARADDR,
  output logic [7:0]                                M_ARLEN,
  output logic [2:0]                                M_ARSIZE,
  output logic [1:0]                                M_ARBURST,
  output logic                                      M_ARVALID,
  input  logic                                      M_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]             M_RDATA,
  input  logic [1:0]                                M_RRESP,
  input  logic                                      M_RLAST,
  input  logic                                      M_RVALID,
  output logic                                      M_RREADY,
  output logic [C_REQ_COUNT-1:0]                    GRANT,
  output logic                                      BUSY
);

  localparam int N  = C_REQ_COUNT;
  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  arb_state_e      state_q, state_d;
  logic [PW-1:0]   rr_ptr_q, next_ptr, g_idx;
  logic [N-1:0]    grant_q, win, rr_req, rr_gnt;
  logic [AW-1:0]   araddr_q, sel_addr;
  logic [7:0]      arlen_q, sel_len;
  logic            ar_accept, burst_done, rready_g, in_data;

`ifdef AXI_RD_ARB_PRIORITY_EN
  assign rr_req = {REQ_ARVALID[N-1:1], 1'b0};
  assign win    = REQ_ARVALID[0] ? N'(1) : rr_gnt;
`else
  assign rr_req = REQ_ARVALID;
  assign win    = rr_gnt;
`endif

  axi_rd_arb_rr #(.N(N), .PW(PW)) u_rr (
    .req (rr_req),
    .ptr (rr_ptr_q),
    .gnt (rr_gnt)
  );

  always_comb begin
    sel_addr = '0;
    sel_len  = '0;
    g_idx    = '0;
    for (int i = 0; i < N; i++) begin
      if (win[i]) begin
        sel_addr = REQ_ARADDR[i*AW +: AW];
        sel_len  = REQ_ARLEN[i*8 +: 8];
      end
      if (grant_q[i]) g_idx = PW'(i);
    end
  end

  // Fixed-priority wins by requester 0 leave the pointer alone so 1..N-1 keep their rotation.
  always_comb begin
    next_ptr = (g_idx == PW'(N-1)) ? '0 : g_idx + 1'b1;
`ifdef AXI_RD_ARB_PRIORITY_EN
    if (grant_q[0]) next_ptr = rr_ptr_q;
`endif
  end

  assign rready_g = |(REQ_RREADY & grant_q);
  assign in_data  = (state_q == DATA);

  always_comb begin
    state_d    = state_q;
    ar_accept  = 1'b0;
    burst_done = 1'b0;
    case (state_q)
      IDLE: if (|REQ_ARVALID) begin
        state_d   = ADDR;
        ar_accept = 1'b1;
      end
      ADDR: if (M_ARREADY) state_d = DATA;
      DATA: if (M_RVALID && rready_g && M_RLAST) begin
        state_d    = IDLE;
        burst_done = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      araddr_q <= '0;
      arlen_q  <= '0;
    end else begin
      state_q <= state_d;
      if (ar_accept) begin
        grant_q  <= win;
        araddr_q <= sel_addr;
        arlen_q  <= sel_len;
      end
      if (burst_done) begin
        grant_q  <= '0;
        rr_ptr_q <= next_ptr;
      end
    end
  end

  // Accept pulse is combinational in IDLE, so mask it while reset is held.
  assign REQ_ARREADY = (ar_accept && !RST) ? win : '0;

  assign M_ARADDR  = araddr_q;
  assign M_ARLEN   = arlen_q;
  assign M_ARSIZE  = axi_size_from_width(DW);
  assign M_ARBURST = AXI_BURST_INCR;
  assign M_ARVALID = (state_q == ADDR);

  assign M_RREADY   = in_data & rready_g;
  assign REQ_RVALID = (in_data && M_RVALID) ? grant_q : '0;
  assign REQ_RDATA  = in_data ? M_RDATA : '0;
  assign REQ_RRESP  = in_data ? M_RRESP : 2'b00;
  assign REQ_RLAST  = in_data & M_RLAST;

  assign GRANT = grant_q;
  assign BUSY  = (state_q != IDLE);

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter with a transaction-level reference model.
module tb_axi_rd_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 512;

  logic            CLK = 1'b0;
  logic            RST;
  logic [N*AW-1:0] REQ_ARADDR;
  logic [N*8-1:0]  REQ_ARLEN;
  logic [N-1:0]    REQ_ARVALID, REQ_ARREADY, REQ_RVALID, REQ_RREADY, GRANT;
  logic [DW-1:0]   REQ_RDATA, M_RDATA;
  logic [1:0]      REQ_RRESP, M_ARBURST, M_RRESP;
  logic            REQ_RLAST, M_ARVALID, M_ARREADY, M_RLAST, M_RVALID, M_RREADY, BUSY;
  logic [AW-1:0]   M_ARADDR;
  logic [7:0]      M_ARLEN;
  logic [2:0]      M_ARSIZE;

  axi_rd_arbiter #(.C_REQ_COUNT(N), .C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(DW)) dut (
    .CLK(CLK), .RST(RST),
    .REQ_ARADDR(REQ_ARADDR), .REQ_ARLEN(REQ_ARLEN), .REQ_ARVALID(REQ_ARVALID),
    .REQ_ARREADY(REQ_ARREADY), .REQ_RDATA(REQ_RDATA), .REQ_RRESP(REQ_RRESP),
    .REQ_RLAST(REQ_RLAST), .REQ_RVALID(REQ_RVALID), .REQ_RREADY(REQ_RREADY),
    .M_ARADDR(M_ARADDR), .M_ARLEN(M_ARLEN), .M_ARSIZE(M_ARSIZE), .M_ARBURST(M_ARBURST),
    .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY), .M_RDATA(M_RDATA), .M_RRESP(M_RRESP),
    .M_RLAST(M_RLAST), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY),
    .GRANT(GRANT), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference model: phase 0=idle, 1=address, 2=data; owner, pointer, captured request.
  int          m_st = 0;
  int          m_g = 0;
  int          m_ptr = 0;
  logic [31:0] m_addr = '0;
  logic [7:0]  m_len = '0;

  function automatic int pick(input logic [N-1:0] req, input int ptr);
`ifdef AXI_RD_ARB_PRIORITY_EN
    if (req[0]) return 0;
`endif
    for (int k = 0; k < N; k++)
      if (req[(ptr + k) % N]) return (ptr + k) % N;
    return 0;
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_st <= 0; m_g <= 0; m_ptr <= 0; m_addr <= '0; m_len <= '0;
    end else begin
      case (m_st)
        0: if (REQ_ARVALID != 0) begin
          m_g    <= pick(REQ_ARVALID, m_ptr);
          m_addr <= REQ_ARADDR[pick(REQ_ARVALID, m_ptr)*AW +: AW];
          m_len  <= REQ_ARLEN[pick(REQ_ARVALID, m_ptr)*8 +: 8];
          m_st   <= 1;
        end
        1: if (M_ARREADY) m_st <= 2;
        default: if (M_RVALID && REQ_RREADY[m_g] && M_RLAST) begin
          m_st <= 0;
`ifdef AXI_RD_ARB_PRIORITY_EN
          if (m_g != 0) m_ptr <= (m_g + 1) % N;
`else
          m_ptr <= (m_g + 1) % N;
`endif
        end
      endcase
    end
  end

  int          gl[$];
  int          rq_idx[$];
  logic [31:0] rq_dat[$];

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("grant",   64'(GRANT),       (m_st != 0) ? (64'd1 << m_g) : 64'd0);
      chk("busy",    64'(BUSY),        64'(m_st != 0));
      chk("arvalid", 64'(M_ARVALID),   64'(m_st == 1));
      chk("araddr",  64'(M_ARADDR),    64'(m_addr));
      chk("arlen",   64'(M_ARLEN),     64'(m_len));
      chk("arsize",  64'(M_ARSIZE),    64'd6);
      chk("arburst", 64'(M_ARBURST),   64'd1);
      chk("arready", 64'(REQ_ARREADY),
          (m_st == 0 && !RST && REQ_ARVALID != 0) ? (64'd1 << pick(REQ_ARVALID, m_ptr)) : 64'd0);
      chk("rvalid",  64'(REQ_RVALID),  (m_st == 2 && M_RVALID) ? (64'd1 << m_g) : 64'd0);
      chk("rready",  64'(M_RREADY),    64'(m_st == 2 && REQ_RREADY[m_g]));
      chk("rresp",   64'(REQ_RRESP),   (m_st == 2) ? 64'(M_RRESP) : 64'd0);
      chk("rlast",   64'(REQ_RLAST),   64'(m_st == 2 && M_RLAST));
      checks++;
      if (REQ_RDATA !== ((m_st == 2) ? M_RDATA : '0)) begin
        failures++;
        $display("FAIL rdata actual=%0h required=%0h", REQ_RDATA[63:0], M_RDATA[63:0]);
      end
      for (int k = 0; k < N; k++) begin
        if (REQ_ARREADY[k]) gl.push_back(k);
        if (REQ_RVALID[k] && REQ_RREADY[k]) begin
          rq_idx.push_back(k);
          rq_dat.push_back(REQ_RDATA[31:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_logs();
    gl.delete(); rq_idx.delete(); rq_dat.delete();
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [7:0] l);
    REQ_ARADDR[i*AW +: AW] = a;
    REQ_ARLEN[i*8 +: 8]    = l;
  endtask

  // Slave side of one burst; requester g drops ARVALID bits in clr once its address is taken.
  task automatic serve(input int g, input int len, input int ar_wait, input logic [N-1:0] clr,
                       input logic [31:0] exp_a, input logic [31:0] base,
                       input int stall_at, input int stall_n);
    int lat, beat, cyc;
    logic hs;
    lat = 0;
    while (!M_ARVALID && lat < 50) begin tick(); lat++; end
    chk("ar_latency", 64'(lat), 64'd1);
    if (!M_ARVALID) return;
    chk("ar_addr", 64'(M_ARADDR), 64'(exp_a));
    for (int w = 0; w < ar_wait; w++) begin
      chk("ar_hold_valid", 64'(M_ARVALID), 64'd1);
      chk("ar_hold_addr",  64'(M_ARADDR),  64'(exp_a));
      tick();
    end
    M_ARREADY = 1'b1;
    tick();
    M_ARREADY = 1'b0;
    REQ_ARVALID = REQ_ARVALID & ~clr;
    beat = 0; cyc = 0;
    while (beat <= len && cyc < 200) begin
      M_RVALID = 1'b1;
      M_RDATA = '0;
      M_RDATA[31:0] = base + 32'(beat);
      M_RRESP = 2'(beat);
      M_RLAST = (beat == len);
      REQ_RREADY[g] = !(cyc >= stall_at && cyc < stall_at + stall_n);
      hs = REQ_RREADY[g];
      tick();
      cyc++;
      if (hs) beat++;
    end
    chk("beats_done", 64'(beat), 64'(len + 1));
    M_RVALID = 1'b0; M_RLAST = 1'b0; M_RRESP = 2'b00; REQ_RREADY[g] = 1'b1;
  endtask

  task automatic check_recv(input int g, input logic [31:0] base, input int n);
    chk("recv_count", 64'(rq_idx.size()), 64'(n));
    for (int i = 0; i < n && i < rq_idx.size(); i++) begin
      chk("recv_owner", 64'(rq_idx[i]), 64'(g));
      chk("recv_data",  64'(rq_dat[i]), 64'(base + 32'(i)));
    end
  endtask

  int exp_order[5];

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1;
    REQ_ARADDR = '0; REQ_ARLEN = '0; REQ_ARVALID = '1; REQ_RREADY = '1;
    M_ARREADY = 1'b0; M_RDATA = '0; M_RRESP = '0; M_RLAST = 1'b0; M_RVALID = 1'b1;
    @(posedge CLK);
    chk_en = 1'b1;
    tick(); tick();
    chk("rst_busy",    64'(BUSY),        64'd0);
    chk("rst_grant",   64'(GRANT),       64'd0);
    chk("rst_arready", 64'(REQ_ARREADY), 64'd0);
    chk("rst_rvalid",  64'(REQ_RVALID),  64'd0);
    chk("rst_rready",  64'(M_RREADY),    64'd0);
    chk("rst_araddr",  64'(M_ARADDR),    64'd0);
    REQ_ARVALID = '0; M_RVALID = 1'b0;
    RST = 1'b0;
    tick();

    // All four request continuously, 4-beat bursts.
    for (int i = 0; i < N; i++) set_req(i, 32'h100 + 32'h1000 * 32'(i), 8'd3);
`ifdef AXI_RD_ARB_PRIORITY_EN
    exp_order = '{0, 0, 0, 0, 0};
`else
    exp_order = '{0, 1, 2, 3, 0};
`endif
    clear_logs();
    REQ_ARVALID = 4'b1111;
    for (int b = 0; b < 5; b++)
      serve(exp_order[b], 3, 0, (b == 4) ? 4'b1111 : 4'b0000,
            32'h100 + 32'h1000 * 32'(exp_order[b]), 32'hA000 + 32'(b * 16), 0, 0);
    chk("rr_grant_count", 64'(gl.size()), 64'd5);
    for (int b = 0; b < 5 && b < gl.size(); b++) chk("rr_grant_order", 64'(gl[b]), 64'(exp_order[b]));
    chk("rr_beat_count", 64'(rq_idx.size()), 64'd20);
    for (int i = 0; i < 20 && i < rq_idx.size(); i++) begin
      chk("rr_beat_owner", 64'(rq_idx[i]), 64'(exp_order[i / 4]));
      chk("rr_beat_data",  64'(rq_dat[i]), 64'(32'hA000 + 32'((i / 4) * 16 + i % 4)));
    end
    tick();

    // Requester 2 alone, single beat.
    clear_logs();
    set_req(2, 32'h1000, 8'd0);
    REQ_ARVALID = 4'b0100;
    serve(2, 0, 0, 4'b0100, 32'h1000, 32'hB000, 0, 0);
    check_recv(2, 32'hB000, 1);
    chk("single_idle_busy",  64'(BUSY),  64'd0);
    chk("single_idle_grant", 64'(GRANT), 64'd0);
    tick();

    // Address channel back-pressure while the requester keeps asserting.
    clear_logs();
    set_req(1, 32'h3000, 8'd1);
    REQ_ARVALID = 4'b0010;
    serve(1, 1, 5, 4'b0010, 32'h3000, 32'hC100, 0, 0);
    chk("ar_single_pulse", 64'(gl.size()), 64'd1);
    check_recv(1, 32'hC100, 2);
    tick();

    // Requester 0 stalls its R channel for three cycles mid-burst.
    clear_logs();
    set_req(0, 32'h4000, 8'd5);
    REQ_ARVALID = 4'b0001;
    serve(0, 5, 0, 4'b0001, 32'h4000, 32'hC000, 1, 3);
    check_recv(0, 32'hC000, 6);
    tick();

    // Reset in the middle of a data burst owned by requester 2.
    clear_logs();
    set_req(2, 32'h5000, 8'd3);
    REQ_ARVALID = 4'b0100;
    for (int w = 0; w < 50 && !M_ARVALID; w++) tick();
    chk("rst_burst_started", 64'(M_ARVALID), 64'd1);
    M_ARREADY = 1'b1; tick(); M_ARREADY = 1'b0;
    REQ_ARVALID = 4'b0000;
    M_RVALID = 1'b1; M_RDATA = '0; M_RDATA[31:0] = 32'hD000; M_RLAST = 1'b0;
    tick();
    M_RDATA[31:0] = 32'hD001;
    #2;
    RST = 1'b1;
    REQ_ARVALID = 4'b1111;
    #1;
    chk("midrst_grant",   64'(GRANT),       64'd0);
    chk("midrst_busy",    64'(BUSY),        64'd0);
    chk("midrst_arvalid", 64'(M_ARVALID),   64'd0);
    chk("midrst_rready",  64'(M_RREADY),    64'd0);
    chk("midrst_rvalid",  64'(REQ_RVALID),  64'd0);
    chk("midrst_arready", 64'(REQ_ARREADY), 64'd0);
    chk("midrst_araddr",  64'(M_ARADDR),    64'd0);
    chk("midrst_arlen",   64'(M_ARLEN),     64'd0);
    tick(); tick();
    clear_logs();
    RST = 1'b0;
    M_RVALID = 1'b0;
    serve(0, 5, 0, 4'b1111, 32'h4000, 32'hE000, 0, 0);
    chk("post_rst_grants", 64'(gl.size()), 64'd1);
    if (gl.size() > 0) chk("post_rst_owner", 64'(gl[0]), 64'd0);
    check_recv(0, 32'hE000, 6);
    tick();

`ifdef AXI_RD_ARB_PRIORITY_EN
    // Requesters 0 and 3 contend continuously; 0 must always win.
    clear_logs();
    set_req(3, 32'h6000, 8'd0);
    REQ_ARVALID = 4'b1001;
    for (int b = 0; b < 3; b++)
      serve(0, 5, 0, (b == 2) ? 4'b1111 : 4'b0000, 32'h4000, 32'hF000, 0, 0);
    chk("prio_grant_count", 64'(gl.size()), 64'd3);
    for (int b = 0; b < gl.size(); b++) chk("prio_owner", 64'(gl[b]), 64'd0);
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_rd_arbiter.md
AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

Interface
REQ-001 The block SHALL have parameter C_REQ_COUNT, default 4: number of read requesters (2..8).
REQ-002 The block SHALL have parameter C_M_AXI_ADDR_WIDTH, default 32: AXI address width.
REQ-003 The block SHALL have parameter C_M_AXI_DATA_WIDTH, default 512: AXI data width.
REQ-004 The block SHALL have ports as follows, with N = C_REQ_COUNT, AW = C_M_AXI_ADDR_WIDTH and DW = C_M_AXI_DATA_WIDTH:
- CLK  in  1  single clock; all logic on its rising edge.
- RST  in  1  reset, asynchronous, active-high.
- REQ_ARADDR  in  N*AW  per-requester burst address, packed; requester i at [i*AW +: AW].
- REQ_ARLEN  in  N*8  per-requester AXI burst length, packed.
- REQ_ARVALID  in  N  per-requester read request.
- REQ_ARREADY  out  N  request accepted (captured).
- REQ_RDATA  out  DW  read data, shared by all requesters.
- REQ_RRESP  out  2  read response, shared.
- REQ_RLAST  out  1  last beat, shared.
- REQ_RVALID  out  N  per-requester data valid.
- REQ_RREADY  in  N  per-requester data ready.
- M_ARADDR  out  AW  AXI read address.
- M_ARLEN  out  8  AXI burst length.
- M_ARSIZE  out  3  AXI beat size.
- M_ARBURST  out  2  AXI burst type.
- M_ARVALID  out  1  AXI address valid.
- M_ARREADY  in  1  AXI address ready.
- M_RDATA  in  DW  AXI read data.
- M_RRESP  in  2  AXI read response.
- M_RLAST  in  1  AXI last beat.
- M_RVALID  in  1  AXI read valid.
- M_RREADY  out  1  AXI read ready.
- GRANT  out  N  one-hot current owner; all zero in IDLE.
- BUSY  out  1  high whenever state is not IDLE.

Function
REQ-005 The block SHALL implement three states: IDLE, ADDR, DATA; only one burst is outstanding at a time.
REQ-006 In IDLE with any REQ_ARVALID bit set, the block SHALL select the winner g as the first set bit at or above rr_ptr, wrapping from N-1 to 0.
REQ-007 In the selection cycle the block SHALL assert REQ_ARREADY[g] for exactly one cycle, register REQ_ARADDR/REQ_ARLEN of g, set GRANT[g] and go to ADDR on the next edge.
REQ-008 In ADDR the block SHALL drive M_ARVALID=1 with the registered address and length, held stable until the cycle M_ARVALID&M_ARREADY, then go to DATA.
REQ-009 M_ARSIZE SHALL be the constant log2(DW/8) and M_ARBURST SHALL be the constant 2'b01 (INCR).
REQ-010 In DATA the block SHALL drive REQ_RVALID[g]=M_RVALID, M_RREADY=REQ_RREADY[g], and REQ_RDATA/REQ_RRESP/REQ_RLAST=M_* combinationally (zero added latency); all other REQ_RVALID bits SHALL be 0.
REQ-011 On a beat with M_RVALID&M_RREADY&M_RLAST the block SHALL go to IDLE, clear GRANT and set rr_ptr=(g+1) mod N.
REQ-012 Outside DATA, M_RREADY SHALL be 0 and all REQ_RVALID bits SHALL be 0; stray M_RVALID SHALL be held off, not dropped.
REQ-013 ARLEN=0 (single beat) SHALL complete normally; request-to-M_ARVALID latency SHALL be 1 cycle; minimum burst turnaround SHALL be 1 IDLE cycle.
REQ-014 A requester lowering REQ_ARVALID before it is granted SHALL simply not be selected; the block SHALL not hold a grant for it.

Reset
REQ-015 While RST is high the block SHALL hold state=IDLE, rr_ptr=0, GRANT=0, BUSY=0, M_ARVALID=0, M_RREADY=0, REQ_ARREADY=0, REQ_RVALID=0, and M_ARADDR/M_ARLEN registers=0.
REQ-016 Reset asserted mid-burst SHALL abandon the burst; the block SHALL not guarantee draining of the downstream slave.

Configuration
REQ-017 With AXI_RD_ARB_PRIORITY_EN defined, requester 0 SHALL win whenever its REQ_ARVALID is set in IDLE, and the remaining requesters SHALL rotate round-robin among themselves.
REQ-018 Without AXI_RD_ARB_PRIORITY_EN, the block SHALL use pure round-robin across all N requesters.

Structure
REQ-019 Package axi_rd_arb_pkg SHALL hold the state enum (IDLE/ADDR/DATA), the AXI_BURST_INCR constant and the AXI size-from-width function.
REQ-020 The round-robin picker (request vector, pointer in; one-hot winner out) SHALL be the sub-module axi_rd_arb_rr.

Verification
REQ-021 The bench SHALL drive REQ_ARVALID=4'b1111 with rr_ptr=0 and ARLEN=3, and check that grants are issued in order 0,1,2,3,0 with 4 beats each.
REQ-022 The bench SHALL make requester 2 alone request with ARLEN=0 and addr 0x1000, and check M_ARADDR=0x1000 one cycle later, a single beat, and return to IDLE.
REQ-023 The bench SHALL hold M_ARREADY low for 5 cycles in ADDR, and check that M_ARVALID and M_ARADDR stay stable and no REQ_ARREADY re-pulses.
REQ-024 The bench SHALL drop REQ_RREADY[g] for 3 beats in DATA, and check that M_RREADY follows and no data is lost or duplicated.
REQ-025 The bench SHALL assert RST in the middle of a DATA beat, and check that all outputs are zero, state is IDLE, and the next grant goes to requester 0.
REQ-026 With AXI_RD_ARB_PRIORITY_EN, the bench SHALL make requesters 0 and 3 request continuously, and check that requester 0 wins every arbitration.
